dmu_sio_rsp_rcv: RTL and testbench

- DMU-side receiver for the SIU→DMU outbound response interface in the iol2clk domain.
- Each packet has one header cycle on sio_dmu_data/sio_dmu_parity, qualified by sio_dmu_hdr_vld, optionally followed by a 4-beat, 64-byte payload.
- The block checks parity per cycle, assembles each packet into a response queue and presents it to the DMU DMA-completion logic on a valid/ready port.
- One credit is returned to the SIU per dequeued entry.

---
 rtl/dmu_sio_pkg.sv | 23 ++
 rtl/dmu_sio_rsp_fifo.sv | 35 +++
 rtl/dmu_sio_rsp_rcv.sv | 92 +++++++++
 tb/tb_dmu_sio_rsp_rcv.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmu_sio_pkg.sv
// dmu_sio_pkg: shared field positions, entry type and parity helper for the SIU response receiver
package dmu_sio_pkg;
  localparam int TYPE_HI = 127;
  localparam int TYPE_LO = 122;
  localparam int TAG_HI = 79;
  localparam int TAG_LO = 64;
  localparam int PAYLOAD_BEATS = 4;
  localparam int GAP_CYCLES = 1;
  typedef enum logic [1:0] {IDLE, GAP, BEAT} rcv_state_t;
  typedef struct packed {
    logic [5:0] rtype;
    logic [15:0] tag;
    logic has_data;
    logic par_err;
    logic [511:0] data;
  } rsp_entry_t;
  function automatic logic odd_par_ok(input logic [127:0] d, input logic [7:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) ok &= (^d[16*i +: 16]) ^ p[i];
    return ok;
  endfunction
endpackage

// File: rtl/dmu_sio_rsp_fifo.sv
// dmu_sio_rsp_fifo: response queue; push and pop may coincide at any occupancy
module dmu_sio_rsp_fifo
  import dmu_sio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             iol2clk,
  input  logic             rst_l,
  input  logic             push,
  input  logic             pop,
  input  rsp_entry_t       wdata,
  output rsp_entry_t       head,
  output logic             vld,
  output logic [PTR_W:0]   count
);
  rsp_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign vld = count != '0;
  assign do_pop = pop & vld;
  assign head = mem[rd_ptr];
  always_ff @(posedge iol2clk or negedge rst_l)
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= wdata;
      wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, push};
      rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, do_pop};
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, do_pop};
    end
endmodule

// File: rtl/dmu_sio_rsp_rcv.sv
// dmu_sio_rsp_rcv: receives SIU response packets, checks parity and queues them for the DMU
module dmu_sio_rsp_rcv
  import dmu_sio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         iol2clk,
  input  logic         rst_l,
  input  logic         sio_dmu_hdr_vld,
  input  logic         sio_dmu_datareq,
  input  logic [127:0] sio_dmu_data,
  input  logic [7:0]   sio_dmu_parity,
  output logic         rsp_vld,
  input  logic         rsp_rdy,
  output logic [5:0]   rsp_type,
  output logic [15:0]  rsp_tag,
  output logic         rsp_has_data,
  output logic [511:0] rsp_data,
  output logic         rsp_par_err,
  output logic         dmu_sio_credit_ret,
  output logic         err_par_sticky,
  output logic         err_ovf_sticky,
  output logic         err_proto_sticky
);
  rcv_state_t state;
  logic [1:0] cnt;
  rsp_entry_t cur, wdata, head;
  logic [PTR_W:0] count;
  logic par_ok, pop, idle, accept, last, push;
  assign par_ok = odd_par_ok(sio_dmu_data, sio_dmu_parity);
  assign pop = rsp_vld & rsp_rdy;
  assign idle = state == IDLE;
  // a same-cycle dequeue frees its slot before the room check
  assign accept = idle & sio_dmu_hdr_vld & ((count - {{PTR_W{1'b0}}, pop}) != (PTR_W+1)'(DEPTH));
  assign last = (state == BEAT) & (cnt == 2'(PAYLOAD_BEATS - 1));
  assign push = (accept & ~sio_dmu_datareq) | last;
  always_comb begin
    wdata = cur;
    wdata.has_data = 1'b1;
    wdata.par_err = cur.par_err | ~par_ok;
    wdata.data[511:384] = sio_dmu_data;
    if (!last) wdata = rsp_entry_t'{rtype: sio_dmu_data[TYPE_HI:TYPE_LO], tag: sio_dmu_data[TAG_HI:TAG_LO],
                                   has_data: 1'b0, par_err: ~par_ok, data: '0};
  end
  always_ff @(posedge iol2clk or negedge rst_l)
    if (!rst_l) begin
      state <= IDLE;
      cnt <= '0;
      cur <= '0;
      dmu_sio_credit_ret <= 1'b0;
      err_par_sticky <= 1'b0;
      err_ovf_sticky <= 1'b0;
      err_proto_sticky <= 1'b0;
    end else begin
      dmu_sio_credit_ret <= pop;
      if (((sio_dmu_hdr_vld & idle) | (state == BEAT)) & ~par_ok) err_par_sticky <= 1'b1;
      if (idle & sio_dmu_hdr_vld & ~accept) err_ovf_sticky <= 1'b1;
      if (~idle & sio_dmu_hdr_vld) err_proto_sticky <= 1'b1;
      case (state)
        IDLE: if (accept & sio_dmu_datareq) begin
          state <= GAP;
          cur <= wdata;
        end
        GAP: begin
          state <= BEAT;
          cnt <= '0;
        end
        default: begin
          cur.data[{cnt, 7'd0} +: 128] <= sio_dmu_data;
          cur.par_err <= cur.par_err | ~par_ok;
          cnt <= cnt + 2'd1;
          if (last) state <= IDLE;
        end
      endcase
    end
  dmu_sio_rsp_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .iol2clk(iol2clk),
    .rst_l(rst_l),
    .push(push),
    .pop(pop),
    .wdata(wdata),
    .head(head),
    .vld(rsp_vld),
    .count(count)
  );
  assign rsp_type = head.rtype;
  assign rsp_tag = head.tag;
  assign rsp_has_data = head.has_data;
  assign rsp_data = head.data;
  assign rsp_par_err = head.par_err;
endmodule

// File: tb/tb_dmu_sio_rsp_rcv.sv
// tb_dmu_sio_rsp_rcv: directed stimulus against a queue-based packet model plus literal checks
module tb_dmu_sio_rsp_rcv;
  localparam int DEPTH = 4;
  logic iol2clk = 1'b0;
  logic rst_l = 1'b0;
  logic sio_dmu_hdr_vld = 1'b0, sio_dmu_datareq = 1'b0, rsp_rdy = 1'b0;
  logic [127:0] sio_dmu_data = '0;
  logic [7:0] sio_dmu_parity = '0;
  logic rsp_vld, rsp_has_data, rsp_par_err, dmu_sio_credit_ret;
  logic err_par_sticky, err_ovf_sticky, err_proto_sticky;
  logic [5:0] rsp_type;
  logic [15:0] rsp_tag;
  logic [511:0] rsp_data;
  int tests = 0, fails = 0;

  always #5 iol2clk = ~iol2clk;

  dmu_sio_rsp_rcv #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .iol2clk(iol2clk), .rst_l(rst_l),
    .sio_dmu_hdr_vld(sio_dmu_hdr_vld), .sio_dmu_datareq(sio_dmu_datareq),
    .sio_dmu_data(sio_dmu_data), .sio_dmu_parity(sio_dmu_parity),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_type(rsp_type), .rsp_tag(rsp_tag),
    .rsp_has_data(rsp_has_data), .rsp_data(rsp_data), .rsp_par_err(rsp_par_err),
    .dmu_sio_credit_ret(dmu_sio_credit_ret), .err_par_sticky(err_par_sticky),
    .err_ovf_sticky(err_ovf_sticky), .err_proto_sticky(err_proto_sticky)
  );

  function automatic logic [7:0] gpar(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ~^d[16*i +: 16];
    return p;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: packets as whole entries in an ordered queue
  typedef struct {
    logic [5:0] t;
    logic [15:0] tag;
    logic hd;
    logic pe;
    logic [511:0] d;
  } ent_t;
  ent_t mq[$];
  ent_t pend;
  int left;
  logic m_bad, exp_credit, exp_par, exp_ovf, exp_proto;

  always @(posedge iol2clk or negedge rst_l)
    if (!rst_l) begin
      mq.delete();
      left = 0;
      exp_credit = 0; exp_par = 0; exp_ovf = 0; exp_proto = 0;
    end else begin
      m_bad = gpar(sio_dmu_data) != sio_dmu_parity;
      exp_credit = mq.size() > 0 && rsp_rdy;
      if (exp_credit) void'(mq.pop_front());
      if (left == 0) begin
        if (sio_dmu_hdr_vld) begin
          if (m_bad) exp_par = 1;
          if (mq.size() == DEPTH) exp_ovf = 1;
          else begin
            pend.t = sio_dmu_data[127:122];
            pend.tag = sio_dmu_data[79:64];
            pend.hd = sio_dmu_datareq;
            pend.pe = m_bad;
            pend.d = '0;
            if (sio_dmu_datareq) left = 5;
            else mq.push_back(pend);
          end
        end
      end else begin
        if (sio_dmu_hdr_vld) exp_proto = 1;
        if (left <= 4) begin
          pend.d[(4-left)*128 +: 128] = sio_dmu_data;
          if (m_bad) begin pend.pe = 1; exp_par = 1; end
        end
        left--;
        if (left == 0) mq.push_back(pend);
      end
    end

  always @(negedge iol2clk)
    if (rst_l) begin
      check("m_vld", 512'(rsp_vld), 512'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("m_type", 512'(rsp_type), 512'(mq[0].t));
        check("m_tag", 512'(rsp_tag), 512'(mq[0].tag));
        check("m_has_data", 512'(rsp_has_data), 512'(mq[0].hd));
        check("m_par_err", 512'(rsp_par_err), 512'(mq[0].pe));
        check("m_data", rsp_data, mq[0].d);
      end
      check("m_credit", 512'(dmu_sio_credit_ret), 512'(exp_credit));
      check("m_par_sticky", 512'(err_par_sticky), 512'(exp_par));
      check("m_ovf_sticky", 512'(err_ovf_sticky), 512'(exp_ovf));
      check("m_proto_sticky", 512'(err_proto_sticky), 512'(exp_proto));
    end

  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic idle_bus();
    sio_dmu_hdr_vld = 0;
    sio_dmu_datareq = 0;
    sio_dmu_data = '0;
    sio_dmu_parity = gpar('0);
  endtask

  task automatic drive(input logic hv, input logic dr, input logic [127:0] d, input int flip);
    sio_dmu_hdr_vld = hv;
    sio_dmu_datareq = dr;
    sio_dmu_data = d;
    sio_dmu_parity = gpar(d) ^ (flip >= 0 ? 8'(1 << flip) : 8'h00);
    tick();
  endtask

  function automatic logic [127:0] hdr_word(input logic [5:0] t, input logic [15:0] tag);
    logic [127:0] d;
    d = '0;
    d[127:122] = t;
    d[79:64] = tag;
    d[7:0] = 8'hA5;
    return d;
  endfunction

  task automatic send(input logic [5:0] t, input logic [15:0] tag, input logic dr,
                      input int flip_beat, input int proto_beat);
    drive(1, dr, hdr_word(t, tag), -1);
    if (dr) begin
      drive(0, 0, 128'hDEAD_BEEF, -1);
      for (int b = 0; b < 4; b++) drive(b == proto_beat, 0, 128'(b + 1), b == flip_beat ? 5 : -1);
    end
    idle_bus();
  endtask

  task automatic drain1();
    rsp_rdy = 1;
    tick();
    rsp_rdy = 0;
  endtask

  logic [511:0] d1234;
  logic [15:0] tags [8];
  int credits, ntag;

  initial begin
    d1234 = {128'd4, 128'd3, 128'd2, 128'd1};
    idle_bus();
    repeat (3) tick();
    check("rst_vld", 512'(rsp_vld), 0);
    check("rst_credit", 512'(dmu_sio_credit_ret), 0);
    check("rst_stickies", 512'({err_par_sticky, err_ovf_sticky, err_proto_sticky}), 0);
    check("rst_data", rsp_data, 0);
    rst_l = 1;
    tick();
    send(6'h2A, 16'hBEEF, 0, -1, -1);
    check("ho_vld", 512'(rsp_vld), 1);
    check("ho_type", 512'(rsp_type), 512'(6'h2A));
    check("ho_tag", 512'(rsp_tag), 512'(16'hBEEF));
    check("ho_has_data", 512'(rsp_has_data), 0);
    check("ho_data", rsp_data, 0);
    drain1();
    check("ho_credit", 512'(dmu_sio_credit_ret), 1);
    check("ho_empty", 512'(rsp_vld), 0);
    tick();
    check("ho_credit_once", 512'(dmu_sio_credit_ret), 0);
    drive(1, 1, hdr_word(6'h11, 16'h1234), -1);
    drive(0, 0, 128'h0, -1);
    for (int b = 0; b < 3; b++) drive(0, 0, 128'(b + 1), -1);
    check("dp_not_yet", 512'(rsp_vld), 0);
    drive(0, 0, 128'd4, -1);
    idle_bus();
    check("dp_vld", 512'(rsp_vld), 1);
    check("dp_data", rsp_data, d1234);
    check("dp_par_err", 512'(rsp_par_err), 0);
    drain1();
    send(6'h05, 16'h0F0F, 1, 2, -1);
    check("pe_par_err", 512'(rsp_par_err), 1);
    check("pe_sticky", 512'(err_par_sticky), 1);
    drain1();
    send(6'h06, 16'h1111, 1, -1, -1);
    check("pe_clean", 512'(rsp_par_err), 0);
    check("pe_sticky_held", 512'(err_par_sticky), 1);
    drain1();
    for (int i = 0; i < 5; i++) send(6'h01, 16'(100 + i), 0, -1, -1);
    check("ovf_sticky", 512'(err_ovf_sticky), 1);
    credits = 0;
    ntag = 0;
    rsp_rdy = 1;
    for (int c = 0; c < 10; c++) begin
      if (rsp_vld && ntag < 8) begin tags[ntag] = rsp_tag; ntag++; end
      tick();
      if (dmu_sio_credit_ret) credits++;
    end
    rsp_rdy = 0;
    check("ovf_credits", 512'(credits), 4);
    check("ovf_entries", 512'(ntag), 4);
    for (int i = 0; i < 4; i++) check("ovf_tag_order", 512'(tags[i]), 512'(100 + i));
    send(6'h22, 16'h2222, 1, -1, 1);
    send(6'h33, 16'h3333, 0, -1, -1);
    check("proto_sticky", 512'(err_proto_sticky), 1);
    check("proto_tag", 512'(rsp_tag), 512'(16'h2222));
    check("proto_data", rsp_data, d1234);
    drain1();
    check("b2b_tag", 512'(rsp_tag), 512'(16'h3333));
    drain1();
    send(6'h3F, 16'h4444, 0, -1, -1);
    drive(1, 1, hdr_word(6'h12, 16'h5555), -1);
    drive(0, 0, 128'h0, -1);
    drive(0, 0, 128'd1, -1);
    drive(0, 0, 128'd2, -1);
    sio_dmu_data = 128'd3;
    sio_dmu_parity = gpar(128'd3);
    rst_l = 0;
    #1;
    check("mr_vld", 512'(rsp_vld), 0);
    check("mr_tag", 512'(rsp_tag), 0);
    check("mr_stickies", 512'({err_par_sticky, err_ovf_sticky, err_proto_sticky}), 0);
    idle_bus();
    repeat (2) tick();
    rst_l = 1;
    repeat (6) tick();
    check("mr_no_entry", 512'(rsp_vld), 0);
    send(6'h2A, 16'h6666, 0, -1, -1);
    check("mr_new_tag", 512'(rsp_tag), 512'(16'h6666));
    drain1();
    send(6'h07, 16'h7777, 1, -1, -1);
    check("mr_new_data", rsp_data, d1234);
    drain1();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d tests run", tests);
    $fatal(1);
  end
endmodule
